// File: rtl/ram_fifo_fwft.sv
// First-word-fall-through FIFO on a registered-read dual-port RAM.
// A one-entry hold register hides the RAM latency at full throughput.

module ram_1r1w_2port #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_DEPTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Read port register reloads every cycle; the array has no reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

module ram_fifo_fwft #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_DEPTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_flush,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic [ADDR_WIDTH:0]   o_count
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DATA_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(DATA_DEPTH - 1);

    if (DATA_DEPTH < 2 || DATA_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("ram_fifo_fwft: DATA_DEPTH out of range");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
    logic                  hold_valid_q, hold_valid_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic [DATA_WIDTH-1:0] ram_rdata;

    logic push;
    logic pop;
    logic issue;
    logic out_busy;

    assign o_wr_ready = (ram_cnt_q < DEPTH_C);
    assign o_rd_valid = hold_valid_q | inflight_q;
    assign o_rd_data  = hold_valid_q ? hold_data_q : ram_rdata;
    assign o_count    = ram_cnt_q
                      + (ADDR_WIDTH+1)'(hold_valid_q)
                      + (ADDR_WIDTH+1)'(inflight_q);

    assign push     = i_wr_valid & o_wr_ready;
    assign pop      = o_rd_valid & i_rd_ready;
    assign out_busy = hold_valid_q | inflight_q;
    // Refill the output stage when it is empty or being drained now.
    assign issue    = (ram_cnt_q != '0) & (~out_busy | pop);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        ram_cnt_d    = ram_cnt_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        inflight_d   = issue;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
        end
        if (issue) begin
            rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
        end

        unique case ({push, issue})
            2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
            2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
            default: ram_cnt_d = ram_cnt_q;
        endcase

        // RAM output is overwritten next edge, so a stalled read must park.
        if (inflight_q && !pop) begin
            hold_valid_d = 1'b1;
            hold_data_d  = ram_rdata;
        end else if (hold_valid_q && pop) begin
            hold_valid_d = 1'b0;
        end

        if (i_flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            ram_cnt_d    = '0;
            hold_valid_d = 1'b0;
            inflight_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ram_cnt_q    <= '0;
            hold_valid_q <= 1'b0;
            inflight_q   <= 1'b0;
            hold_data_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ram_cnt_q    <= ram_cnt_d;
            hold_valid_q <= hold_valid_d;
            inflight_q   <= inflight_d;
            hold_data_q  <= hold_data_d;
        end
    end

    ram_1r1w_2port #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_DEPTH (DATA_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (push & ~i_flush),
        .waddr_i (wr_ptr_q),
        .wdata_i (i_wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_ram_fifo_fwft.sv
// Directed bench for ram_fifo_fwft.
// Inputs change and outputs are sampled on the falling edge.

module tb_ram_fifo_fwft;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fl;
    logic        wv;
    logic        wr_rdy;
    logic [31:0] wd;
    logic        rd_vld;
    logic        rr;
    logic [31:0] rd;
    logic [4:0]  cnt;

    int nchk = 0;
    int nerr = 0;

    logic [31:0] q[$];
    logic [31:0] exp_v;
    logic [31:0] prev_d;
    logic        prev_stall;
    logic [39:0] stall_pat;

    always #5 clk = ~clk;

    ram_fifo_fwft #(
        .ADDR_WIDTH (4),
        .DATA_DEPTH (16),
        .DATA_WIDTH (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (fl),
        .i_wr_valid (wv),
        .o_wr_ready (wr_rdy),
        .i_wr_data  (wd),
        .o_rd_valid (rd_vld),
        .i_rd_ready (rr),
        .o_rd_data  (rd),
        .o_count    (cnt)
    );

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        fl = 1'b0;
        wv = 1'b0;
        wd = '0;
        rr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_wr_ready", 32'(wr_rdy), 1);
        chk("rst_rd_valid", 32'(rd_vld), 0);
        chk("rst_count", 32'(cnt), 0);
        rst_n = 1'b1;

        // single push, two-cycle latency
        @(negedge clk);
        wv = 1'b1;
        wd = 32'hA0;
        @(negedge clk);
        wv = 1'b0;
        chk("lat_cnt_c2", 32'(cnt), 1);
        chk("lat_vld_c2", 32'(rd_vld), 0);
        @(negedge clk);
        chk("lat_vld_c3", 32'(rd_vld), 1);
        chk("lat_dat_c3", rd, 32'hA0);
        chk("lat_cnt_c3", 32'(cnt), 1);
        @(negedge clk);
        chk("lat_vld_c4", 32'(rd_vld), 1);
        chk("lat_dat_c4", rd, 32'hA0);
        rr = 1'b1;
        @(negedge clk);
        rr = 1'b0;
        chk("lat_pop_vld", 32'(rd_vld), 0);
        chk("lat_pop_cnt", 32'(cnt), 0);

        // fill to capacity 17
        for (int i = 0; i < 17; i++) begin
            wv = 1'b1;
            wd = 32'(i);
            chk("fill_ready", 32'(wr_rdy), 1);
            @(negedge clk);
        end
        chk("full_ready", 32'(wr_rdy), 0);
        chk("full_cnt", 32'(cnt), 17);
        chk("full_vld", 32'(rd_vld), 1);
        chk("full_dat", rd, 0);
        wd = 32'h99;
        @(negedge clk);
        wv = 1'b0;
        chk("full_rej_cnt", 32'(cnt), 17);

        // drain every cycle with no gaps
        rr = 1'b1;
        for (int i = 0; i < 17; i++) begin
            chk("drain_vld", 32'(rd_vld), 1);
            chk("drain_dat", rd, 32'(i));
            chk("drain_cnt", 32'(cnt), 32'(17 - i));
            if (i == 0) chk("drain_rdy0", 32'(wr_rdy), 0);
            if (i == 1) chk("drain_rdy1", 32'(wr_rdy), 1);
            @(negedge clk);
        end
        rr = 1'b0;
        chk("drain_end_vld", 32'(rd_vld), 0);
        chk("drain_end_cnt", 32'(cnt), 0);

        // streaming with stalls of 1..3 cycles
        stall_pat = 40'b0000_1110_0000_0100_0011_0000_1000_0110_0001_1100;
        prev_stall = 1'b0;
        prev_d = '0;
        for (int n = 0; n < 40; n++) begin
            wv = 1'b1;
            wd = 32'h100 + 32'(n);
            rr = ~stall_pat[n];
            if (prev_stall) chk("strm_stable", rd, prev_d);
            if (rd_vld && rr) begin
                if (q.size() > 0) begin
                    exp_v = q.pop_front();
                    chk("strm_dat", rd, exp_v);
                end else begin
                    chk("strm_spur_vld", 32'(rd_vld), 0);
                end
            end
            if (wr_rdy) q.push_back(wd);
            prev_stall = rd_vld & ~rr;
            prev_d = rd;
            @(negedge clk);
        end
        wv = 1'b0;
        rr = 1'b1;
        for (int k = 0; k < 60 && q.size() > 0; k++) begin
            if (rd_vld) begin
                exp_v = q.pop_front();
                chk("strm_drain", rd, exp_v);
            end
            @(negedge clk);
        end
        rr = 1'b0;
        chk("strm_left", 32'(q.size()), 0);
        chk("strm_end_cnt", 32'(cnt), 0);

        // flush with 5 entries and a concurrent push
        for (int i = 1; i <= 5; i++) begin
            wv = 1'b1;
            wd = 32'(i);
            @(negedge clk);
        end
        chk("pre_flush_cnt", 32'(cnt), 5);
        wd = 32'h55;
        fl = 1'b1;
        @(negedge clk);
        fl = 1'b0;
        wv = 1'b0;
        chk("flush_cnt", 32'(cnt), 0);
        chk("flush_vld", 32'(rd_vld), 0);
        chk("flush_rdy", 32'(wr_rdy), 1);
        repeat (3) begin
            @(negedge clk);
            chk("flush_no55", 32'(rd_vld), 0);
        end
        wv = 1'b1;
        wd = 32'h66;
        @(negedge clk);
        wv = 1'b0;
        chk("post_flush_vld1", 32'(rd_vld), 0);
        @(negedge clk);
        chk("post_flush_vld2", 32'(rd_vld), 1);
        chk("post_flush_dat", rd, 32'h66);
        rr = 1'b1;
        @(negedge clk);
        rr = 1'b0;
        chk("post_flush_pop", 32'(rd_vld), 0);
        chk("post_flush_cnt", 32'(cnt), 0);

        // async reset between edges
        for (int i = 0; i < 4; i++) begin
            wv = 1'b1;
            wd = 32'h200 + 32'(i);
            @(negedge clk);
        end
        chk("pre_rst_vld", 32'(rd_vld), 1);
        #2;
        rst_n = 1'b0;
        wv = 1'b0;
        #1;
        chk("arst_vld", 32'(rd_vld), 0);
        chk("arst_cnt", 32'(cnt), 0);
        chk("arst_rdy", 32'(wr_rdy), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_cnt", 32'(cnt), 0);
        wv = 1'b1;
        wd = 32'h77;
        @(negedge clk);
        wv = 1'b0;
        chk("rel_cnt1", 32'(cnt), 1);
        @(negedge clk);
        chk("rel_vld", 32'(rd_vld), 1);
        chk("rel_dat", rd, 32'h77);
        rr = 1'b1;
        @(negedge clk);
        rr = 1'b0;
        chk("rel_end_cnt", 32'(cnt), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
